// File: rtl/core_ctrl_pkg.sv
// Shared types and sizing for the host-side run controller of the single-cycle core.
// Command opcodes, controller states and the default IRAM / counter widths.
package core_ctrl_pkg;

  localparam int IRAM_DEPTH = 16;
  localparam int ADDR_W     = 4;
  localparam int CNT_W      = 16;

  typedef enum logic [1:0] {
    OP_LOAD = 2'd0,
    OP_DATA = 2'd1,
    OP_RUN  = 2'd2,
    OP_RSVD = 2'd3
  } cmd_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_HALT = 2'd3
  } state_e;

endpackage

// File: rtl/run_budget_counter.sv
// Cycle budget for a RUN burst: a loadable down-counter that flags its final enabled
// cycle, plus a saturating count of core cycles executed since the last reset release.
module run_budget_counter
  import core_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] budget,
  input  logic             count_en,
  input  logic             clear,
  output logic             expire,
  output logic [CNT_W-1:0] cycles_run
);

  logic [CNT_W-1:0] remaining_q;

  // High during the last enabled cycle of the burst, so the controller stops on the next edge.
  assign expire = count_en && (remaining_q == CNT_W'(1));

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      remaining_q <= '0;
      cycles_run  <= '0;
    end else begin
      if (load)
        remaining_q <= budget;
      else if (count_en && remaining_q != '0)
        remaining_q <= remaining_q - CNT_W'(1);

      if (clear)
        cycles_run <= '0;
      else if (count_en && cycles_run != '1)
        cycles_run <= cycles_run + CNT_W'(1);
    end
  end

endmodule

// File: rtl/core_run_ctrl.sv
// Command sequencer: loads the core's instruction RAM, releases the core from reset,
// runs it for an exact cycle budget, then freezes it for logic-analyzer readback.
module core_run_ctrl
  import core_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [31:0]       cmd_data,
  input  logic              abort,
  output logic              iram_write,
  output logic [ADDR_W-1:0] iram_select,
  output logic [31:0]       iram_data,
  output logic              core_rst_n,
  output logic              core_clk_en,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [CNT_W-1:0]  cycles_run
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   widx_q, widx_d;
  logic [ADDR_W:0]     nwords_q, nwords_d;
  logic                write_d, done_d, err_d;
  logic [ADDR_W-1:0]   sel_d;
  logic [31:0]         data_d;
  logic                budget_load, cnt_clear, expire;

  cmd_op_e             op;
  logic                accept;
  logic [ADDR_W:0]     load_n;
  logic                load_ok;
  logic [CNT_W-1:0]    budget;
  logic [ADDR_W:0]     widx_next;

  assign op        = cmd_op_e'(cmd_op);
  assign cmd_ready = (state_q != ST_RUN) && !abort;
  assign accept    = cmd_valid && cmd_ready;
  assign load_n    = cmd_data[ADDR_W:0];
  assign load_ok   = (load_n != '0) && (load_n <= (ADDR_W+1)'(IRAM_DEPTH));
  assign budget    = cmd_data[CNT_W-1:0];
  assign widx_next = {1'b0, widx_q} + (ADDR_W+1)'(1);

  run_budget_counter u_budget (
    .clk        (clk),
    .rst        (rst),
    .load       (budget_load),
    .budget     (budget),
    .count_en   (state_q == ST_RUN),
    .clear      (cnt_clear),
    .expire     (expire),
    .cycles_run (cycles_run)
  );

  always_comb begin
    // NOTE: every signal gets a default first, so no path through the block can infer a latch.
    state_d     = state_q;
    widx_d      = widx_q;
    nwords_d    = nwords_q;
    write_d     = 1'b0;
    sel_d       = iram_select;
    data_d      = iram_data;
    done_d      = 1'b0;
    err_d       = 1'b0;
    budget_load = 1'b0;
    cnt_clear   = 1'b0;

    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_HALT: begin
          if (accept) begin
            case (op)
              OP_LOAD: begin
                if (load_ok) begin
                  state_d   = ST_LOAD;
                  widx_d    = '0;
                  nwords_d  = load_n;
                  cnt_clear = (state_q == ST_HALT);
                end else begin
                  err_d = 1'b1;
                end
              end
              OP_RUN: begin
                // A fresh release from reset restarts the count; a HALT resume keeps it.
                cnt_clear = (state_q == ST_IDLE);
                if (budget == '0) begin
                  state_d = ST_HALT;
                  done_d  = 1'b1;
                end else begin
                  state_d     = ST_RUN;
                  budget_load = 1'b1;
                end
              end
              default: err_d = 1'b1;
            endcase
          end
        end
        ST_LOAD: begin
          if (accept) begin
            if (op == OP_DATA) begin
              write_d = 1'b1;
              sel_d   = widx_q;
              data_d  = cmd_data;
              widx_d  = widx_q + ADDR_W'(1);
              if (widx_next == nwords_q) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
              end
            end else begin
              err_d = 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (expire) begin
            state_d = ST_HALT;
            done_d  = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      widx_q      <= '0;
      nwords_q    <= '0;
      iram_write  <= 1'b0;
      iram_select <= '0;
      iram_data   <= '0;
      core_rst_n  <= 1'b0;
      core_clk_en <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      state_q     <= state_d;
      widx_q      <= widx_d;
      nwords_q    <= nwords_d;
      iram_write  <= write_d;
      iram_select <= sel_d;
      iram_data   <= data_d;
      core_rst_n  <= (state_d == ST_RUN) || (state_d == ST_HALT);
      core_clk_en <= (state_d == ST_RUN);
      busy        <= (state_d == ST_LOAD) || (state_d == ST_RUN);
      done        <= done_d;
      err         <= err_d;
    end
  end

endmodule
